mem_access_unit: RTL

Load/store front end placed directly upstream of the data memory (async read, sync write, word-addressed by `addr >> 2`). It accepts one CPU load/store request at a time over a valid/ready handshake. It turns byte and halfword stores into a read-modify-write of the containing word, and extracts and sign- or zero-extends sub-word load data. It returns a one-cycle response pulse with data or an error flag.

---
 rtl/mem_access_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end for a word-wide data memory.
// Accepts one request at a time. Sub-word stores become a read-modify-write
// of the containing word. Sub-word loads are extracted from the word and then
// sign- or zero-extended. Each request ends with a one-cycle response pulse.
// Optional build macro: MAU_MISALIGN_CHECK_EN enables misaligned-access errors.
// Without it, word requests ignore addr[1:0] and halfword requests ignore addr[0].
module mem_access_unit #(
    parameter int MEM_DEPTH = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

    localparam logic [1:0]  SZ_BYTE    = 2'b00;
    localparam logic [1:0]  SZ_HALF    = 2'b01;
    localparam logic [1:0]  SZ_WORD    = 2'b10;
    localparam logic [1:0]  SZ_BAD     = 2'b11;
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_DEPTH) * 33'd4;

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_write;
    logic        r_unsigned;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_word;
    logic [31:0] r_rdata;
    logic        w_accept;
    logic        w_reqErr;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_loadData;
    logic [31:0] w_merged;

    assign w_accept   = req_valid && (r_state == S_IDLE);
    assign mem_addr   = {r_addr[31:2], 2'b00};
    assign resp_rdata = r_rdata;

    // Classify the incoming request as rejected (bad size, out of range, misaligned)
    always_comb begin
        w_reqErr = (req_size == SZ_BAD) || ({1'b0, req_addr} >= ADDR_LIMIT);
`ifdef MAU_MISALIGN_CHECK_EN
        if ((req_size == SZ_HALF) && req_addr[0]) begin
            w_reqErr = 1'b1;
        end
        if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) begin
            w_reqErr = 1'b1;
        end
`endif
    end

    // State register; reset returns to IDLE at once, aborting any pending write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode: loads and sub-word stores read first, word stores write directly
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_reqErr) begin
                        w_nextState = S_RESP;
                    end else if (req_write && (req_size == SZ_WORD)) begin
                        w_nextState = S_WRITE;
                    end else begin
                        w_nextState = S_READ;
                    end
                end
            end
            S_READ:  w_nextState = r_write ? S_WRITE : S_RESP;
            S_WRITE: w_nextState = S_RESP;
            S_RESP:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Latch the request at acceptance so memory signals never depend on live req_* inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr     <= '0;
            r_size     <= SZ_BYTE;
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= req_addr;
            r_size     <= req_size;
            r_write    <= req_write;
            r_unsigned <= req_unsigned;
            r_wdata    <= req_wdata;
            r_err      <= w_reqErr;
        end
    end

    // Capture the memory word during READ; it feeds the store merge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word <= '0;
        end else if (r_state == S_READ) begin
            r_word <= mem_dout;
        end
    end

    // Pick the addressed lane of the read word and extend it to 32 bits
    always_comb begin
        w_byte     = mem_dout[{r_addr[1:0], 3'b000} +: 8];
        w_half     = r_addr[1] ? mem_dout[31:16] : mem_dout[15:0];
        w_loadData = mem_dout;
        case (r_size)
            SZ_BYTE: w_loadData = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: w_loadData = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: w_loadData = mem_dout;
        endcase
    end

    // Replace only the addressed lane of the captured word with the store data
    always_comb begin
        w_merged = r_word;
        case (r_size)
            SZ_BYTE: w_merged[{r_addr[1:0], 3'b000} +: 8]  = r_wdata[7:0];
            SZ_HALF: w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            default: w_merged = r_wdata;
        endcase
    end

    // Response data is loaded once on entry to RESP and held until the next response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if ((w_nextState == S_RESP) && (r_state != S_RESP)) begin
            r_rdata <= (r_state == S_READ) ? w_loadData : '0;
        end
    end

    // Output decode from state and latched request only
    always_comb begin
        req_ready  = (r_state == S_IDLE);
        mem_read   = (r_state == S_READ);
        mem_write  = (r_state == S_WRITE);
        mem_din    = (r_state == S_WRITE) ? w_merged : '0;
        resp_valid = (r_state == S_RESP);
        resp_err   = (r_state == S_RESP) && r_err;
    end

endmodule
